md_sched: RTL and testbench



---
 rtl/md_sched_pkg.sv | 24 ++
 rtl/md_sched_if.sv | 23 ++
 rtl/md_sched_watchdog.sv | 27 ++
 rtl/md_sched.sv | 110 +++++++++++
 tb/tb_md_sched.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/md_sched_pkg.sv
// Shared encodings for the mul/div sequencer: FSM states, engine start
// levels, pipeline stall levels and the latched-operand record.
package md_sched_pkg;

  localparam logic [1:0] MD_IDLE  = 2'd0;
  localparam logic [1:0] MD_BUSY  = 2'd1;
  localparam logic [1:0] MD_DONE  = 2'd2;
  localparam logic [1:0] MD_DRAIN = 2'd3;

  localparam logic MD_START = 1'b1;
  localparam logic MD_STOP  = 1'b0;

  // Stall request levels as seen by the pipeline controller.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef struct packed {
    logic        div;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
  } md_op_t;

endpackage

// File: rtl/md_sched_if.sv
// Level start/ready handshake between md_sched (master) and the shared
// iterative div_mul engine (slave).
interface md_sched_if;

    logic        eng_start;
    logic        eng_div;
    logic        eng_signed;
    logic [31:0] eng_x;
    logic [31:0] eng_y;
    logic [63:0] eng_result;
    logic        eng_ready;

    modport master (
        output eng_start, eng_div, eng_signed, eng_x, eng_y,
        input  eng_result, eng_ready
    );

    modport slave (
        input  eng_start, eng_div, eng_signed, eng_x, eng_y,
        output eng_result, eng_ready
    );

endinterface

// File: rtl/md_sched_watchdog.sv
// md_watchdog: busy-cycle counter; expired pulses on the last allowed cycle
// while enabled, so the owner can bail out before the limit is exceeded.
module md_watchdog #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = en && (cnt == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/md_sched.sv
// md_sched: EX-stage sequencer for the shared mul/div engine.
// Optional build macro MD_SCHED_DIV0_BYPASS_EN short-circuits divide-by-zero.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_hold,
    input  logic        req,
    input  logic        req_div,
    input  logic        req_signed,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        stallreq_md,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        err_timeout,
    md_sched_if.master  eng
);

    logic [1:0] state;
    md_op_t     op;
    logic       wd_expired;
    logic       div0;

`ifdef MD_SCHED_DIV0_BYPASS_EN
    assign div0 = req_div && (req_b == 32'd0);
`else
    assign div0 = 1'b0;
`endif

    md_watchdog #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != MD_BUSY),
        .en      (state == MD_BUSY),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= MD_IDLE;
            op          <= '0;
            res_hi      <= '0;
            res_lo      <= '0;
            err_timeout <= 1'b0;
        end else if (flush) begin
            // Leaving BUSY must pass through DRAIN so the engine sees start drop.
            state <= (state == MD_BUSY) ? MD_DRAIN : MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (req) begin
                        op <= '{div: req_div, sgn: req_signed, a: req_a, b: req_b};
                        if (div0) begin
                            res_hi <= req_a;
                            res_lo <= '1;
                            state  <= MD_DONE;
                        end else begin
                            state  <= MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (eng.eng_ready) begin
                        {res_hi, res_lo} <= eng.eng_result;
                        state            <= MD_DONE;
                    end else if (wd_expired) begin
                        res_hi      <= '0;
                        res_lo      <= '0;
                        err_timeout <= 1'b1;
                        state       <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!ex_hold) state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    // DONE is only ever left through IDLE or flush, so it doubles as the valid flag.
    assign res_valid = (state == MD_DONE);

    // NOTE: always_comb gets a default first so no latch is inferred.
    always_comb begin
        stallreq_md = NO_STOP;
        case (state)
            MD_IDLE, MD_DRAIN: stallreq_md = req;
            MD_BUSY:           stallreq_md = STOP;
            default:           stallreq_md = NO_STOP;
        endcase
    end

    assign eng.eng_start  = (state == MD_BUSY) ? MD_START : MD_STOP;
    assign eng.eng_div    = op.div;
    assign eng.eng_signed = op.sgn;
    assign eng.eng_x      = op.a;
    assign eng.eng_y      = op.b;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: the bench plays the div_mul engine and the
// pipeline, checking each cycle a few nanoseconds after the rising edge.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        rst, flush, ex_hold, req, req_div, req_signed;
    logic [31:0] req_a, req_b;
    logic        stallreq_md, res_valid, err_timeout;
    logic [31:0] res_hi, res_lo;

    int n_checks = 0;
    int n_fail   = 0;

    md_sched_if eng ();

    md_sched #(.MAX_CYCLES(40), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ex_hold     (ex_hold),
        .req         (req),
        .req_div     (req_div),
        .req_signed  (req_signed),
        .req_a       (req_a),
        .req_b       (req_b),
        .stallreq_md (stallreq_md),
        .res_valid   (res_valid),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .err_timeout (err_timeout),
        .eng         (eng.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r, input logic d, input logic s,
                           input logic [31:0] a, input logic [31:0] b);
        req        = r;
        req_div    = d;
        req_signed = s;
        req_a      = a;
        req_b      = b;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        eng.eng_ready  = 1'b0;
        eng.eng_result = 64'd0;

        // Reset state
        step(); step(); #2;
        check("rst_stall", stallreq_md, 1'b0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_err",   err_timeout, 1'b0);
        check("rst_start", eng.eng_start, 1'b0);
        check("rst_res",   {res_hi, res_lo}, 64'd0);
        rst = 1'b0;

        // mult 7*6, engine ready on the 3rd busy cycle
        step(); set_req(1'b1, 1'b0, 1'b0, 32'd7, 32'd6); #2;
        check("mul_c0_stall", stallreq_md, 1'b1);
        check("mul_c0_start", eng.eng_start, 1'b0);
        step(); #2;
        check("mul_c1_stall", stallreq_md, 1'b1);
        check("mul_c1_start", eng.eng_start, 1'b1);
        check("mul_c1_ops",   {eng.eng_x, eng.eng_y}, {32'd7, 32'd6});
        check("mul_c1_div",   eng.eng_div, 1'b0);
        step(); req_a = 32'd999; #2;
        check("mul_c2_latched", eng.eng_x, 32'd7);
        step(); eng.eng_ready = 1'b1; eng.eng_result = 64'd42; #2;
        check("mul_c3_stall", stallreq_md, 1'b1);
        check("mul_c3_valid", res_valid, 1'b0);
        step(); eng.eng_ready = 1'b0; eng.eng_result = 64'hBAD; req = 1'b0; #2;
        check("mul_c4_valid", res_valid, 1'b1);
        check("mul_c4_res",   {res_hi, res_lo}, 64'd42);
        check("mul_c4_stall", stallreq_md, 1'b0);
        check("mul_c4_start", eng.eng_start, 1'b0);
        step(); #2;
        check("mul_c5_valid", res_valid, 1'b0);

        // divu 100/7 held across 5 frozen cycles
        set_req(1'b1, 1'b1, 1'b0, 32'd100, 32'd7); #2;
        check("divu_c0_stall", stallreq_md, 1'b1);
        step(); eng.eng_ready = 1'b1; eng.eng_result = {32'd2, 32'd14}; #2;
        check("divu_c1_div",   eng.eng_div, 1'b1);
        check("divu_c1_start", eng.eng_start, 1'b1);
        step(); eng.eng_ready = 1'b0; eng.eng_result = '1; ex_hold = 1'b1; #2;
        for (int i = 0; i < 5; i++) begin
            check("divu_hold_valid", res_valid, 1'b1);
            check("divu_hold_res",   {res_hi, res_lo}, {32'd2, 32'd14});
            check("divu_hold_stall", stallreq_md, 1'b0);
            if (i < 4) begin step(); #2; end
        end
        step(); ex_hold = 1'b0; req = 1'b0; #2;
        check("divu_release_valid", res_valid, 1'b1);
        step(); #2;
        check("divu_idle_valid", res_valid, 1'b0);
        check("divu_idle_stall", stallreq_md, 1'b0);

        // flush in 2nd busy cycle coinciding with eng_ready
        set_req(1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
        step(); #2;
        step(); flush = 1'b1; eng.eng_ready = 1'b1; eng.eng_result = 64'hDEAD_BEEF_DEAD_BEEF; #2;
        check("fl_busy_start", eng.eng_start, 1'b1);
        step(); flush = 1'b0; eng.eng_ready = 1'b0; req = 1'b0; #2;
        check("fl_drain_start", eng.eng_start, 1'b0);
        check("fl_drain_valid", res_valid, 1'b0);
        check("fl_drain_stall", stallreq_md, 1'b0);
        check("fl_not_captured", {res_hi, res_lo}, {32'd2, 32'd14});
        step(); set_req(1'b1, 1'b0, 1'b0, 32'd9, 32'd9); #2;
        check("fl_idle_start", eng.eng_start, 1'b0);
        check("fl_idle_stall", stallreq_md, 1'b1);
        step(); #2;
        check("fl_new_start", eng.eng_start, 1'b1);
        check("fl_new_x",     eng.eng_x, 32'd9);
        eng.eng_ready = 1'b1; eng.eng_result = 64'd81;
        step(); eng.eng_ready = 1'b0; set_req(1'b1, 1'b0, 1'b0, 32'd11, 32'd13); #2;
        check("fl_new_res",   {res_hi, res_lo}, 64'd81);
        check("b2b_done_stall", stallreq_md, 1'b0);
        step(); #2;
        check("b2b_idle_valid", res_valid, 1'b0);
        check("b2b_idle_start", eng.eng_start, 1'b0);
        check("b2b_idle_stall", stallreq_md, 1'b1);

        // eng_ready on the 40th busy cycle wins over the watchdog
        step();
        for (int i = 1; i <= 40; i++) begin
            if (i == 40) begin eng.eng_ready = 1'b1; eng.eng_result = 64'd143; end
            #2;
            if (i == 1 || i == 40) check("race_busy_stall", stallreq_md, 1'b1);
            if (i < 40) step();
        end
        step(); eng.eng_ready = 1'b0; req = 1'b0; #2;
        check("race_valid", res_valid, 1'b1);
        check("race_res",   {res_hi, res_lo}, 64'd143);
        check("race_err",   err_timeout, 1'b0);

        // engine never ready: watchdog on the 40th busy cycle
        step(); set_req(1'b1, 1'b0, 1'b0, 32'd1, 32'd1);
        step();
        for (int i = 1; i <= 40; i++) begin
            #2;
            if (i == 40) begin
                check("wd_c40_stall", stallreq_md, 1'b1);
                check("wd_c40_err",   err_timeout, 1'b0);
            end
            if (i < 40) step();
        end
        step(); req = 1'b0; #2;
        check("wd_err",   err_timeout, 1'b1);
        check("wd_valid", res_valid, 1'b1);
        check("wd_res",   {res_hi, res_lo}, 64'd0);
        check("wd_stall", stallreq_md, 1'b0);
        step(); #2;
        check("wd_sticky", err_timeout, 1'b1);
        check("wd_idle_valid", res_valid, 1'b0);

        // signed divide by zero
        set_req(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'd0); #2;
        check("d0_c0_stall", stallreq_md, 1'b1);
        step(); #2;
`ifdef MD_SCHED_DIV0_BYPASS_EN
        check("d0_start",  eng.eng_start, 1'b0);
        check("d0_valid",  res_valid, 1'b1);
        check("d0_res",    {res_hi, res_lo}, {32'h8000_0000, 32'hFFFF_FFFF});
        check("d0_stall",  stallreq_md, 1'b0);
        req = 1'b0;
`else
        check("d0_start",  eng.eng_start, 1'b1);
        check("d0_mode",   {eng.eng_div, eng.eng_signed}, 2'b11);
        check("d0_ops",    {eng.eng_x, eng.eng_y}, {32'h8000_0000, 32'd0});
        check("d0_busy_valid", res_valid, 1'b0);
        eng.eng_ready = 1'b1; eng.eng_result = {32'h8000_0000, 32'hFFFF_FFFF};
        step(); eng.eng_ready = 1'b0; req = 1'b0; #2;
        check("d0_res", {res_hi, res_lo}, {32'h8000_0000, 32'hFFFF_FFFF});
`endif
        step(); #2;
        check("d0_idle_valid", res_valid, 1'b0);

        // synchronous reset mid-BUSY
        set_req(1'b1, 1'b0, 1'b0, 32'd5, 32'd5);
        step(); #2;
        check("rb_busy_start", eng.eng_start, 1'b1);
        check("rb_busy_err",   err_timeout, 1'b1);
        rst = 1'b1; req = 1'b0;
        step(); #2;
        check("rb_start", eng.eng_start, 1'b0);
        check("rb_stall", stallreq_md, 1'b0);
        check("rb_valid", res_valid, 1'b0);
        check("rb_err",   err_timeout, 1'b0);
        check("rb_res",   {res_hi, res_lo}, 64'd0);
        check("rb_ops",   {eng.eng_div, eng.eng_signed, eng.eng_x, eng.eng_y}, 66'd0);
        rst = 1'b0;
        step(); #2;
        check("rb_idle_start", eng.eng_start, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
